sccb_init_sequencer: RTL and testbench
======================================

Name: sccb_init_sequencer

Overview:
- Walks a camera register-init table stored in an external synchronous ROM.
- Issues one SCCB write per entry through the existing SCCB controller, using a start/done handshake.
- Table entries can also insert millisecond delays; failed writes are retried.
- Sits between the system bring-up logic and the SCCB controller. It is the only requester that drives the controller during init (e.g. OV2640 at device ID 0x60).

Parameters:
- ADDR_W, 8: ROM address width; the table holds up to 2^ADDR_W entries.
- DEV_ADDR, 8'h60: SCCB write device ID driven on sccb_addr_id.
- MAX_RETRY, 3: extra attempts per entry after the first ack error or timeout.
- CYCLES_PER_MS, 50_000: XCLK cycles per delay millisecond (50 MHz XCLK); benches override with a small value.
- TIMEOUT_CYCLES, 2_000_000: cycles in WAIT_DONE without sccb_done before the attempt counts as failed.

Ports:
- XCLK  in  1  system clock; all logic on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- init_start  in  1  1-cycle pulse; begins the table walk from entry 0
- init_busy  out  1  high from the cycle after init_start is accepted until DONE/FAIL
- init_done  out  1  level; table completed successfully
- init_error  out  1  level; an entry exhausted its retries
- err_index  out  ADDR_W  index of the failing entry; valid while init_error=1
- rom_addr  out  ADDR_W  table read address
- rom_data  in  16  entry {reg[15:8], val[7:0]}; valid 1 cycle after rom_addr
- sccb_start  out  1  1-cycle pulse requesting one 3-phase write
- sccb_addr_id  out  8  constant DEV_ADDR
- sccb_addr_reg  out  8  register address; held from ISSUE until sccb_done
- sccb_data  out  8  write data; held from ISSUE until sccb_done
- sccb_done  in  1  1-cycle pulse from the controller at end of transaction
- sccb_ack_error  in  1  sampled only when sccb_done=1; 1 means a NACK occurred

Behaviour:
- Reset values: all outputs 0, except sccb_addr_id = DEV_ADDR. State = IDLE, retry counter = 0, delay and timeout counters = 0.
- Entry decode:
  - 16'hFFFF: end of table.
  - reg = 8'hFE: delay of val ms; val = 0 means no delay, proceed immediately.
  - Any other value: SCCB write of val to reg. Register 0xFF (bank select) is a normal write unless val is also 0xFF.
- IDLE: on init_start, set rom_addr = 0 and go to FETCH. init_busy rises on the next cycle.
- FETCH: one cycle while ROM data settles, then go to DECODE.
- DECODE: latch rom_data.
  - End marker: go to DONE.
  - Delay entry: load counter = val*CYCLES_PER_MS and go to DELAY.
  - Otherwise: go to ISSUE.
- ISSUE: sccb_start = 1 for exactly one cycle. Drive sccb_addr_reg/sccb_data; clear the timeout counter. Go to WAIT_DONE.
  - The first sccb_start occurs 3 cycles after the init_start sampling edge.
- WAIT_DONE:
  - sccb_done with ack_error = 0: clear the retry counter, go to NEXT.
  - sccb_done with ack_error = 1, or timeout reached: if retry < MAX_RETRY, increment retry and return to ISSUE with the same entry; else go to FAIL.
  - sccb_done and timeout in the same cycle: sccb_done takes priority.
- DELAY: decrement the counter each cycle; at 0 go to NEXT. No SCCB activity during DELAY.
- NEXT:
  - If rom_addr = 2^ADDR_W-1, go to DONE (no wrap; this entry was the last one processed).
  - Else rom_addr + 1, go to FETCH.
- DONE: init_busy = 0, init_done = 1.
- FAIL: init_busy = 0, init_error = 1, err_index = rom_addr.
- DONE/FAIL: init_start clears done/error/err_index and restarts from entry 0.
- Ignored inputs:
  - init_start while busy has no effect.
  - sccb_done outside WAIT_DONE is ignored.
- Attempt limit: total attempts per entry is MAX_RETRY+1.
- RST_N low mid-transaction: immediately return to reset values. sccb_start drops asynchronously; the controller is reset by the same RST_N.

Test Plan:
- Table {EE:FE, 12:80, FFFF}, controller model acks after 20 cycles -> two sccb_start pulses carrying (EE,FE) then (12,80). init_done=1, init_error=0, rom_addr ends at 2.
- Table {FE:03, 11:01, FFFF}, CYCLES_PER_MS=10 -> the first sccb_start occurs ≥30 cycles after entry 0 is decoded. Writes (11,01); done.
- Entry 1 NACKed twice then acked, MAX_RETRY=3 -> entry 1 gets 3 sccb_start pulses in total. init_done=1.
- Entry 1 always NACKed, MAX_RETRY=3 -> exactly 4 pulses for entry 1. init_error=1, err_index=1, no access to entry 2.
- Controller never returns sccb_done, TIMEOUT_CYCLES=100 -> re-issue every ~101 cycles, 4 attempts, then FAIL.
- Stress sequence -> each of the following holds:
  - init_start pulsed mid-walk is ignored.
  - RST_N asserted during WAIT_DONE zeroes all outputs within the same cycle.
  - After release, init_start restarts from entry 0.
  - A table with no end marker and ADDR_W=2 ends in DONE after entry 3.

Source files
------------

// File: rtl/sccb_init_sequencer.sv
// sccb_init_sequencer
// Walks a camera register-init table held in an external synchronous ROM and
// turns each entry into one SCCB write (or a millisecond delay), retrying
// writes that NACK or time out. Stops at the end marker or after the last
// addressable entry.
module sccb_init_sequencer #(
   parameter int         ADDR_W         = 8,
   parameter logic [7:0] DEV_ADDR       = 8'h60,
   parameter int         MAX_RETRY      = 3,
   parameter int         CYCLES_PER_MS  = 50_000,
   parameter int         TIMEOUT_CYCLES = 2_000_000
) (
   input  logic              XCLK,
   input  logic              RST_N,
   input  logic              init_start,
   output logic              init_busy,
   output logic              init_done,
   output logic              init_error,
   output logic [ADDR_W-1:0] err_index,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              sccb_start,
   output logic [7:0]        sccb_addr_id,
   output logic [7:0]        sccb_addr_reg,
   output logic [7:0]        sccb_data,
   input  logic              sccb_done,
   input  logic              sccb_ack_error
);

   // Delay counter must hold 255 ms worth of cycles; timeout counter must
   // reach TIMEOUT_CYCLES without wrapping.
   localparam int DLY_W = $clog2(255 * CYCLES_PER_MS + 1);
   localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [DLY_W-1:0] CPMS_V    = DLY_W'(CYCLES_PER_MS);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

   localparam logic [7:0]  DELAY_REG  = 8'hFE;
   localparam logic [15:0] END_MARKER = 16'hFFFF;

   typedef struct packed {
      logic [7:0] rg;
      logic [7:0] val;
   } entry_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT,
      S_DELAY,
      S_NEXT,
      S_DONE,
      S_FAIL
   } state_t;

   state_t             state_q, state_d;
   entry_t             ent;
   logic [DLY_W-1:0]   dly_q;
   logic [TMO_W-1:0]   tmo_q;
   logic [RTY_W-1:0]   retry_q;

   logic is_end, is_dly, dly_zero;
   logic last_entry, tmo_hit, retry_ok;
   logic wr_ok, wr_bad;
   logic can_start;

   assign ent        = entry_t'(rom_data);
   assign is_end     = (rom_data == END_MARKER);
   assign is_dly     = (ent.rg == DELAY_REG);
   assign dly_zero   = (ent.val == 8'h00);
   assign last_entry = (rom_addr == {ADDR_W{1'b1}});
   assign tmo_hit    = (tmo_q == TMO_LAST);
   assign retry_ok   = (retry_q < RETRY_MAX);

   // A done pulse always wins over a coincident timeout.
   assign wr_ok  = sccb_done && !sccb_ack_error;
   assign wr_bad = (sccb_done && sccb_ack_error) || (!sccb_done && tmo_hit);

   // Only the resting states accept a new walk; busy states ignore init_start.
   assign can_start = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);

   // Status and handshake outputs decode straight from the state register so
   // they follow RST_N asynchronously.
   assign sccb_start   = (state_q == S_ISSUE);
   assign init_busy    = !can_start;
   assign init_done    = (state_q == S_DONE);
   assign init_error   = (state_q == S_FAIL);
   assign sccb_addr_id = DEV_ADDR;

   // State register.
   always_ff @(posedge XCLK or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic for the table walk.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (init_start) state_d = S_FETCH;
         end
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (is_end)      state_d = S_DONE;
            else if (is_dly) state_d = dly_zero ? S_NEXT : S_DELAY;
            else             state_d = S_ISSUE;
         end
         S_ISSUE:  state_d = S_WAIT;
         S_WAIT: begin
            if (wr_ok)       state_d = S_NEXT;
            else if (wr_bad) state_d = retry_ok ? S_ISSUE : S_FAIL;
         end
         S_DELAY: begin
            if (dly_q == '0) state_d = S_NEXT;
         end
         S_NEXT:   state_d = last_entry ? S_DONE : S_FETCH;
         default:  state_d = S_IDLE;
      endcase
   end

   // Table address: rewound on a new walk, advanced after each finished entry.
   always_ff @(posedge XCLK or negedge RST_N) begin
      if (!RST_N) begin
         rom_addr <= '0;
      end else if (can_start && init_start) begin
         rom_addr <= '0;
      end else if (state_q == S_NEXT && !last_entry) begin
         rom_addr <= rom_addr + ADDR_W'(1);
      end
   end

   // Write payload: captured once per entry and held across all retries.
   always_ff @(posedge XCLK or negedge RST_N) begin
      if (!RST_N) begin
         sccb_addr_reg <= 8'h00;
         sccb_data     <= 8'h00;
      end else if (state_q == S_DECODE && !is_end && !is_dly) begin
         sccb_addr_reg <= ent.rg;
         sccb_data     <= ent.val;
      end
   end

   // Millisecond delay counter, loaded from the entry and counted down to 0.
   always_ff @(posedge XCLK or negedge RST_N) begin
      if (!RST_N) begin
         dly_q <= '0;
      end else if (state_q == S_DECODE && is_dly && !is_end) begin
         dly_q <= DLY_W'(ent.val) * CPMS_V;
      end else if (state_q == S_DELAY && dly_q != '0) begin
         dly_q <= dly_q - DLY_W'(1);
      end
   end

   // Transaction watchdog: restarted on every issue, counts while waiting.
   always_ff @(posedge XCLK or negedge RST_N) begin
      if (!RST_N) begin
         tmo_q <= '0;
      end else if (state_q == S_ISSUE) begin
         tmo_q <= '0;
      end else if (state_q == S_WAIT && !sccb_done && !tmo_hit) begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   // Retry counter: cleared per walk and per successful write, bumped on a
   // failed attempt that still has budget left.
   always_ff @(posedge XCLK or negedge RST_N) begin
      if (!RST_N) begin
         retry_q <= '0;
      end else if (can_start && init_start) begin
         retry_q <= '0;
      end else if (state_q == S_WAIT) begin
         if (wr_ok)                   retry_q <= '0;
         else if (wr_bad && retry_ok) retry_q <= retry_q + RTY_W'(1);
      end
   end

   // Failing entry index, recorded on the last failed attempt, cleared on restart.
   always_ff @(posedge XCLK or negedge RST_N) begin
      if (!RST_N) begin
         err_index <= '0;
      end else if (can_start && init_start) begin
         err_index <= '0;
      end else if (state_q == S_WAIT && wr_bad && !retry_ok) begin
         err_index <= rom_addr;
      end
   end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb_sccb_init_sequencer
// Drives the sequencer with a small synchronous ROM and an SCCB controller
// model (random latency, programmable NACKs, optional silence). A table-level
// model predicts the ordered list of writes and the final outcome; a negedge
// monitor compares every issued write and holding behaviour against it.
module tb_sccb_init_sequencer;
   localparam int AW   = 2;
   localparam int MAXR = 3;
   localparam int CPMS = 10;
   localparam int TMO  = 100;

   logic          XCLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          init_start = 1'b0;
   logic          init_busy, init_done, init_error;
   logic [AW-1:0] err_index, rom_addr;
   logic [15:0]   rom_data;
   logic          sccb_start;
   logic [7:0]    sccb_addr_id, sccb_addr_reg, sccb_data;
   logic          sccb_done, sccb_ack_error;

   sccb_init_sequencer #(
      .ADDR_W(AW), .DEV_ADDR(8'h60), .MAX_RETRY(MAXR),
      .CYCLES_PER_MS(CPMS), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .XCLK(XCLK), .RST_N(RST_N), .init_start(init_start),
      .init_busy(init_busy), .init_done(init_done), .init_error(init_error),
      .err_index(err_index), .rom_addr(rom_addr), .rom_data(rom_data),
      .sccb_start(sccb_start), .sccb_addr_id(sccb_addr_id),
      .sccb_addr_reg(sccb_addr_reg), .sccb_data(sccb_data),
      .sccb_done(sccb_done), .sccb_ack_error(sccb_ack_error)
   );

   always #5 XCLK = ~XCLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- environment ----------------
   int cyc = 0;
   always @(posedge XCLK) cyc <= cyc + 1;

   logic [15:0] rom [4];
   always @(posedge XCLK) rom_data <= rom[rom_addr];

   // controller config (written only by the stimulus process)
   logic [7:0] nack_reg   = 8'h00;
   int         nack_n     = 0;
   bit         never_done = 1'b0;
   int         lat_min    = 1;
   int         lat_max    = 25;

   int         pend;
   int         given;
   logic [7:0] cur_reg;

   // SCCB controller model: done pulse some cycles after each start; NACKs
   // the first nack_n writes to nack_reg; ack_error is noise outside done.
   always @(posedge XCLK or negedge RST_N) begin
      if (!RST_N) begin
         pend <= -1; given <= 0; cur_reg <= 8'h00;
         sccb_done <= 1'b0; sccb_ack_error <= 1'b0;
      end else begin
         sccb_done      <= 1'b0;
         sccb_ack_error <= 1'($urandom);
         if (sccb_start) begin
            pend    <= never_done ? -1 : int'($urandom_range(lat_max, lat_min));
            cur_reg <= sccb_addr_reg;
         end else if (pend == 0) begin
            sccb_done <= 1'b1;
            if (cur_reg == nack_reg && given < nack_n) begin
               sccb_ack_error <= 1'b1;
               given <= given + 1;
            end else begin
               sccb_ack_error <= 1'b0;
            end
            pend <= -1;
         end else if (pend > 0) begin
            pend <= pend - 1;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [15:0] exp_w [64];
   int          n_exp;
   bit          exp_done, exp_err;
   int          exp_idx, exp_addr;

   // Walk the table the way the spec describes it: list every write attempt
   // in order and decide how the walk ends.
   task automatic build_model();
      int         g;
      bit         ok;
      logic [15:0] e;
      g = 0; n_exp = 0;
      exp_done = 1'b1; exp_err = 1'b0; exp_idx = 0; exp_addr = 3;
      for (int i = 0; i < 4; i++) begin
         e = rom[i];
         if (e == 16'hFFFF) begin exp_addr = i; return; end
         if (e[15:8] == 8'hFE) continue;
         ok = 1'b0;
         for (int a = 0; a <= MAXR; a++) begin
            exp_w[n_exp] = e; n_exp++;
            if (never_done) continue;
            if (e[15:8] == nack_reg && g < nack_n) g++;
            else begin ok = 1'b1; break; end
         end
         if (!ok) begin
            exp_done = 1'b0; exp_err = 1'b1; exp_idx = i; exp_addr = i;
            return;
         end
      end
   endtask

   // ---------------- compare process ----------------
   int          n_start;
   int          start_cyc [64];
   logic [15:0] held;
   bit          held_v;
   int          max_addr;

   always @(negedge XCLK) begin
      if (!RST_N) begin
         n_start <= 0; held_v <= 1'b0; max_addr <= 0;
      end else begin
         chk("addr_id", {24'h0, sccb_addr_id}, 32'h60);
         chk("flags_excl", {31'h0, (int'(init_busy) + int'(init_done) + int'(init_error)) <= 1}, 1);
         if (int'(rom_addr) > max_addr) max_addr <= int'(rom_addr);
         if (sccb_start) begin
            chk("busy_on_start", {31'h0, init_busy}, 1);
            chk("write_entry", {16'h0, sccb_addr_reg, sccb_data},
                (n_start < n_exp) ? {16'h0, exp_w[n_start]} : 32'hDEAD_BEEF);
            if (n_start < 64) start_cyc[n_start] <= cyc;
            n_start <= n_start + 1;
            held    <= {sccb_addr_reg, sccb_data};
            held_v  <= 1'b1;
         end else if (held_v) begin
            chk("write_hold", {16'h0, sccb_addr_reg, sccb_data}, {16'h0, held});
            if (sccb_done) held_v <= 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   int t0;

   task automatic do_reset();
      RST_N = 1'b0;
      repeat (3) @(negedge XCLK);
      #2 RST_N = 1'b1;
   endtask

   task automatic load(input logic [15:0] a, b, c, d);
      rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
   endtask

   // One full walk: pulse start, wait (bounded) for done/error, check outcome.
   task automatic run(input bit poke);
      bit fin;
      build_model();
      @(negedge XCLK); init_start = 1'b1;
      @(posedge XCLK); #1 t0 = cyc;
      @(negedge XCLK); init_start = 1'b0;
      fin = 1'b0;
      for (int t = 0; t < 3000 && !fin; t++) begin
         @(negedge XCLK);
         init_start = (poke && t == 4 && init_busy);
         fin = init_done | init_error;
      end
      init_start = 1'b0;
      chk("walk_finished", {31'h0, fin}, 1);
      chk("init_done", {31'h0, init_done}, {31'h0, exp_done});
      chk("init_error", {31'h0, init_error}, {31'h0, exp_err});
      chk("err_index", {30'h0, err_index}, exp_err ? exp_idx : 0);
      chk("rom_addr_end", {30'h0, rom_addr}, exp_addr);
      chk("n_writes", n_start, n_exp);
      chk("busy_end", {31'h0, init_busy}, 0);
   endtask

   logic [7:0] rg, vv;
   int         k;

   initial begin
      // reset state
      load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      #12;
      chk("rst_outputs", {init_busy, init_done, init_error, err_index, rom_addr,
                          sccb_start, sccb_addr_reg, sccb_data}, 0);
      chk("rst_addr_id", {24'h0, sccb_addr_id}, 32'h60);
      do_reset();

      // two plain writes then end marker
      load(16'hEEFE, 16'h1280, 16'hFFFF, 16'hFFFF);
      run(1'b0);
      chk("model_t1_writes", n_exp, 2);
      chk("model_t1_addr", exp_addr, 2);
      // start seen on the negedge 2 cycles after sampling -> controller samples it 3 cycles after
      chk("first_start_lat", start_cyc[0] - t0, 2);

      // 3 ms delay first (30 cycles), then one write
      do_reset();
      load(16'hFE03, 16'h1101, 16'hFFFF, 16'hFFFF);
      run(1'b0);
      chk("model_t2_writes", n_exp, 1);
      chk("delay_min", {31'h0, (start_cyc[0] - t0) >= 32}, 1);
      chk("delay_max", {31'h0, (start_cyc[0] - t0) <= 40}, 1);

      // entry 1 NACKed twice then acked
      do_reset();
      nack_reg = 8'h1C; nack_n = 2;
      load(16'h0A0B, 16'h1C1D, 16'hFFFF, 16'hFFFF);
      run(1'b0);
      chk("model_t3_writes", n_exp, 4);

      // entry 1 always NACKed: four attempts then fail, entry 2 never read
      do_reset();
      nack_n = 99;
      run(1'b0);
      chk("model_t4_writes", n_exp, 5);
      chk("model_t4_idx", exp_idx, 1);
      chk("no_entry2_access", {31'h0, max_addr <= 1}, 1);

      // silent controller: watchdog re-issues every TMO+1 cycles
      do_reset();
      nack_n = 0; never_done = 1'b1;
      load(16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      run(1'b0);
      chk("model_t5_writes", n_exp, 4);
      for (int i = 1; i < 4; i++) chk("retry_interval", start_cyc[i] - start_cyc[i-1], 101);
      never_done = 1'b0;

      // no end marker, bank-select write, mid-walk init_start ignored
      do_reset();
      load(16'hFF01, 16'hFE01, 16'h2233, 16'h4455);
      run(1'b1);
      chk("model_noend_addr", exp_addr, 3);
      chk("model_noend_writes", n_exp, 3);

      // reset asserted while waiting for the controller
      do_reset();
      lat_min = 20; lat_max = 25;
      load(16'h5566, 16'h7788, 16'hFFFF, 16'hFFFF);
      build_model();
      @(negedge XCLK); init_start = 1'b1;
      @(negedge XCLK); init_start = 1'b0;
      for (int t = 0; t < 100 && n_start < 1; t++) @(negedge XCLK);
      chk("reached_wait", {31'h0, n_start >= 1}, 1);
      @(posedge XCLK); #2 RST_N = 1'b0;
      #1;
      chk("rst_mid_outputs", {init_busy, init_done, init_error, err_index, rom_addr,
                              sccb_start, sccb_addr_reg, sccb_data}, 0);
      repeat (2) @(negedge XCLK);
      #2 RST_N = 1'b1;
      run(1'b0);

      // randomized tables and NACK plans
      lat_min = 1; lat_max = 25;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 4; i++) begin
            k = int'($urandom_range(9, 0));
            if (k == 0) rom[i] = 16'hFFFF;
            else if (k < 3) rom[i] = {8'hFE, 8'($urandom_range(2, 0))};
            else begin
               rg = 8'($urandom); vv = 8'($urandom);
               if (rg == 8'hFE) rg = 8'hFD;
               if ({rg, vv} == 16'hFFFF) vv = 8'h00;
               rom[i] = {rg, vv};
            end
         end
         k = int'($urandom_range(3, 0));
         nack_reg = rom[k][15:8];
         nack_n = int'($urandom_range(5, 0));
         do_reset();
         run(r[0]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
